// File: rtl/c7bicu_fetch_resp_if.sv
// Fetch-response signal bundle: IFU->ICU fetch handshake plus the ICU->BIU read channel.
// IFU side: req is held until ack (ack is combinational in the same cycle); the response
// is a single data_valid pulse; cancel discards whatever fetch is outstanding.
// BIU side: req/addr are held stable until ack; read data arrives later as a one-cycle data_valid.
interface c7bicu_fetch_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_icu_req_ic1;
    logic [ADDR_W-1:0] ifu_icu_addr_ic1;
    logic              ifu_icu_cancel;
    logic              icu_ifu_ack_ic1;
    logic              icu_ifu_data_valid_ic2;
    logic [DATA_W-1:0] icu_ifu_data_ic2;
    logic              icu_ifu_err_ic2;
    logic              icu_biu_req;
    logic [ADDR_W-1:0] icu_biu_addr;
    logic              biu_icu_ack;
    logic              biu_icu_data_valid;
    logic [DATA_W-1:0] biu_icu_data;

    modport slave (
        input  ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
        output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2, icu_ifu_err_ic2,
        output icu_biu_req, icu_biu_addr,
        input  biu_icu_ack, biu_icu_data_valid, biu_icu_data
    );

    modport master (
        output ifu_icu_req_ic1, ifu_icu_addr_ic1, ifu_icu_cancel,
        input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2, icu_ifu_err_ic2,
        input  icu_biu_req, icu_biu_addr,
        output biu_icu_ack, biu_icu_data_valid, biu_icu_data
    );
endinterface

// File: rtl/c7bicu_fetch_resp.sv
// ICU responder for IFU fetches: accepts one request, reads the word over the BIU
// (single outstanding), returns it as a one-cycle pulse, and honours IFU cancel.
module c7bicu_fetch_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    c7bicu_fetch_resp_if.slave      fetch,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              biu_req_q, biu_req_d;
    logic [ADDR_W-1:0] biu_addr_q, biu_addr_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              ack;
    logic              aligned;
    logic              bus_data;

    assign ack     = fetch.ifu_icu_req_ic1 && (state == IDLE) && !fetch.ifu_icu_cancel;
    assign aligned = (fetch.ifu_icu_addr_ic1[1:0] == 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            biu_req_q  <= 1'b0;
            biu_addr_q <= '0;
            dv_q       <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            biu_req_q  <= biu_req_d;
            biu_addr_q <= biu_addr_d;
            dv_q       <= dv_d;
            data_q     <= data_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state;
        biu_req_d  = biu_req_q;
        biu_addr_d = biu_addr_q;
        dv_d       = 1'b0;
        data_d     = data_q;
        err_d      = err_q;
        drop_d     = drop_q;
        bus_data   = 1'b0;
        case (state)
            IDLE: begin
                if (ack) begin
                    if (aligned) begin
                        biu_req_d  = 1'b1;
                        biu_addr_d = fetch.ifu_icu_addr_ic1;
                        state_d    = BUS_REQ;
                    end else begin
                        dv_d    = 1'b1;
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUS_REQ: begin
                if (fetch.biu_icu_ack) begin
                    biu_req_d = 1'b0;
                    bus_data  = fetch.biu_icu_data_valid;
                    state_d   = BUS_WAIT;
                end
            end
            BUS_WAIT: bus_data = fetch.biu_icu_data_valid;
            RESP:     state_d  = IDLE;
            default:  state_d  = IDLE;
        endcase

        // A cancelled fetch still lets the bus read finish; its data is simply discarded.
        if (state == BUS_REQ || state == BUS_WAIT) begin
            if (fetch.ifu_icu_cancel) begin
                drop_d = 1'b1;
            end
            if (bus_data) begin
                if (drop_q || fetch.ifu_icu_cancel) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    dv_d    = 1'b1;
                    data_d  = fetch.biu_icu_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
        end
    end

    assign fetch.icu_ifu_ack_ic1        = ack;
    assign fetch.icu_ifu_data_valid_ic2 = dv_q && !fetch.ifu_icu_cancel;
    assign fetch.icu_ifu_data_ic2       = data_q;
    assign fetch.icu_ifu_err_ic2        = err_q;
    assign fetch.icu_biu_req            = biu_req_q;
    assign fetch.icu_biu_addr           = biu_addr_q;
    assign dbg_state                    = state;

endmodule

// File: tb/tb_c7bicu_fetch_resp.sv
// Bench for c7bicu_fetch_resp: directed scenarios and random traffic against a
// transaction-level reference model with an expected-response queue.
module tb_c7bicu_fetch_resp;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int W      = DATA_W + 1;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] dbg_state;

    c7bicu_fetch_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fetch_if ();

    c7bicu_fetch_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .fetch     (fetch_if),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, ack_cyc = 0, ack_gap = 0, lat_last = 0, n_acks = 0, n_dv = 0;
    bit last_ack = 1'b0;

    // BIU responder knobs and progress
    int          bb_phase = 0, bb_cnt = 0, ack_dly = 0, dat_dly = 0;
    bit          bb_rand = 1'b0, bb_fixed_en = 1'b0;
    logic [31:0] bb_fixed = '0;

    // Reference model: outstanding-fetch bookkeeping and expected responses
    bit                m_busy = 0, m_bus_req = 0, m_wait_data = 0, m_drop = 0, m_resp = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_hold = '0;
    logic [W-1:0]      exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_bus_req = 0; m_wait_data = 0; m_drop = 0; m_resp = 0;
        m_addr = '0; m_hold = '0;
        exp_q.delete();
    endtask

    task automatic cycle();
        logic         exp_ack, exp_dv, data_now, resp_next;
        logic [W-1:0] e;
        fetch_if.biu_icu_ack        = 1'b0;
        fetch_if.biu_icu_data_valid = 1'b0;
        fetch_if.biu_icu_data       = bb_fixed_en ? bb_fixed : $urandom;
        if (bb_phase == 0 && fetch_if.icu_biu_req) begin
            if (bb_rand) begin
                ack_dly = $urandom_range(0, 3);
                dat_dly = $urandom_range(0, 3);
            end
            bb_phase = 1;
            bb_cnt   = ack_dly;
        end
        if (bb_phase == 1) begin
            if (bb_cnt == 0) begin
                fetch_if.biu_icu_ack = 1'b1;
                if (dat_dly == 0) begin
                    fetch_if.biu_icu_data_valid = 1'b1;
                    bb_phase = 0;
                end else begin
                    bb_phase = 2;
                    bb_cnt   = dat_dly - 1;
                end
            end else begin
                bb_cnt--;
            end
        end else if (bb_phase == 2) begin
            if (bb_cnt == 0) begin
                fetch_if.biu_icu_data_valid = 1'b1;
                bb_phase = 0;
            end else begin
                bb_cnt--;
            end
        end

        @(negedge clk);
        cyc++;
        exp_ack = fetch_if.ifu_icu_req_ic1 && !m_busy && !fetch_if.ifu_icu_cancel;
        check("ack", fetch_if.icu_ifu_ack_ic1, exp_ack);
        check("biu_req", fetch_if.icu_biu_req, m_bus_req);
        if (m_bus_req) check("biu_addr", fetch_if.icu_biu_addr, m_addr);
        exp_dv = m_resp && !fetch_if.ifu_icu_cancel;
        check("data_valid", fetch_if.icu_ifu_data_valid_ic2, exp_dv);
        if (m_resp) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            if (exp_dv) begin
                check("data", fetch_if.icu_ifu_data_ic2, e[DATA_W-1:0]);
                check("err", fetch_if.icu_ifu_err_ic2, e[DATA_W]);
            end
        end else begin
            check("data_hold", fetch_if.icu_ifu_data_ic2, m_hold);
        end

        last_ack = fetch_if.icu_ifu_ack_ic1;
        if (last_ack) begin
            ack_gap = cyc - ack_cyc;
            ack_cyc = cyc;
            n_acks++;
        end
        if (fetch_if.icu_ifu_data_valid_ic2) begin
            lat_last = cyc - ack_cyc;
            n_dv++;
        end

        resp_next = 1'b0;
        if (m_resp) begin
            m_resp = 0;
            m_busy = 0;
        end
        if (exp_ack) begin
            m_busy = 1;
            if (fetch_if.ifu_icu_addr_ic1[1:0] == 2'b00) begin
                m_bus_req = 1;
                m_addr    = fetch_if.ifu_icu_addr_ic1;
            end else begin
                exp_q.push_back({1'b1, {DATA_W{1'b0}}});
                m_hold    = '0;
                resp_next = 1'b1;
            end
        end else if (m_bus_req || m_wait_data) begin
            data_now = fetch_if.biu_icu_data_valid && (m_wait_data || fetch_if.biu_icu_ack);
            if (fetch_if.ifu_icu_cancel) m_drop = 1;
            if (m_bus_req && fetch_if.biu_icu_ack) begin
                m_bus_req   = 0;
                m_wait_data = 1;
            end
            if (data_now) begin
                m_wait_data = 0;
                if (m_drop) begin
                    m_drop = 0;
                    m_busy = 0;
                end else begin
                    exp_q.push_back({1'b0, fetch_if.biu_icu_data});
                    m_hold    = fetch_if.biu_icu_data;
                    resp_next = 1'b1;
                end
            end
        end
        m_resp = resp_next;

        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            cycle();
            got = last_ack;
        end
        if (!got) check("ack_timeout", 0, 1);
    endtask

    task automatic ifu_fetch(input logic [ADDR_W-1:0] a);
        fetch_if.ifu_icu_req_ic1  = 1'b1;
        fetch_if.ifu_icu_addr_ic1 = a;
        wait_ack();
        fetch_if.ifu_icu_req_ic1  = 1'b0;
    endtask

    task automatic set_bus(input int a_dly, input int d_dly, input logic [31:0] word);
        bb_rand     = 1'b0;
        ack_dly     = a_dly;
        dat_dly     = d_dly;
        bb_fixed_en = 1'b1;
        bb_fixed    = word;
    endtask

    int a0, d0;

    initial begin
        fetch_if.ifu_icu_req_ic1    = 1'b0;
        fetch_if.ifu_icu_addr_ic1   = '0;
        fetch_if.ifu_icu_cancel     = 1'b0;
        fetch_if.biu_icu_ack        = 1'b0;
        fetch_if.biu_icu_data_valid = 1'b0;
        fetch_if.biu_icu_data       = '0;
        #2;
        check("rst_state", dbg_state, 2'd0);
        check("rst_biu_req", fetch_if.icu_biu_req, 1'b0);
        check("rst_biu_addr", fetch_if.icu_biu_addr, 0);
        check("rst_dv", fetch_if.icu_ifu_data_valid_ic2, 1'b0);
        check("rst_data", fetch_if.icu_ifu_data_ic2, 0);
        check("rst_err", fetch_if.icu_ifu_err_ic2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // aligned fetch
        set_bus(1, 2, 32'hDEADBEEF);
        d0 = n_dv;
        ifu_fetch(32'h0000_1000);
        run(6);
        check("aligned_lat", lat_last, 5);
        check("aligned_dv_count", n_dv - d0, 1);

        // zero-wait bus, back-to-back requests
        set_bus(0, 0, 32'hA5A5_0001);
        ifu_fetch(32'h0000_1100);
        ifu_fetch(32'h0000_1104);
        check("zero_wait_lat", lat_last, 2);
        check("zero_wait_ack_gap", ack_gap, 3);
        run(4);

        // misaligned fetch
        ifu_fetch(32'h0000_1002);
        run(1);
        check("misaligned_lat", lat_last, 1);
        run(2);

        // cancel while waiting for bus data
        set_bus(0, 4, 32'h12345678);
        ifu_fetch(32'h0000_3000);
        run(1);
        d0 = n_dv;
        fetch_if.ifu_icu_cancel = 1'b1;
        cycle();
        fetch_if.ifu_icu_cancel = 1'b0;
        run(6);
        check("cancel_no_dv", n_dv - d0, 0);
        check("cancel_idle", dbg_state, 2'd0);
        set_bus(1, 1, 32'h0BAD_F00D);
        ifu_fetch(32'h0000_2000);
        run(5);
        check("after_cancel_dv", n_dv - d0, 1);

        // held request while the bus withholds ack
        set_bus(6, 1, 32'h5555_AAAA);
        ifu_fetch(32'h0000_5000);
        a0 = n_acks;
        fetch_if.ifu_icu_req_ic1  = 1'b1;
        fetch_if.ifu_icu_addr_ic1 = 32'h0000_4000;
        run(9);
        check("busy_no_ack", n_acks - a0, 0);
        wait_ack();
        fetch_if.ifu_icu_req_ic1 = 1'b0;
        check("busy_lat", lat_last, 9);
        check("busy_ack_gap", ack_gap, 10);
        run(12);

        // async reset in the middle of a bus wait
        set_bus(0, 5, 32'hCAFE_F00D);
        ifu_fetch(32'h0000_6000);
        run(2);
        d0 = n_dv;
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_biu_req", fetch_if.icu_biu_req, 1'b0);
        check("mid_rst_biu_addr", fetch_if.icu_biu_addr, 0);
        check("mid_rst_dv", fetch_if.icu_ifu_data_valid_ic2, 1'b0);
        check("mid_rst_data", fetch_if.icu_ifu_data_ic2, 0);
        check("mid_rst_err", fetch_if.icu_ifu_err_ic2, 1'b0);
        check("mid_rst_ack", fetch_if.icu_ifu_ack_ic1, 1'b0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run(8);
        check("late_biu_ignored", n_dv - d0, 0);

        // random traffic
        bb_rand     = 1'b1;
        bb_fixed_en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!fetch_if.ifu_icu_req_ic1 && $urandom_range(0, 1) == 1) begin
                fetch_if.ifu_icu_req_ic1  = 1'b1;
                fetch_if.ifu_icu_addr_ic1 = $urandom;
                if ($urandom_range(0, 3) != 0) fetch_if.ifu_icu_addr_ic1[1:0] = 2'b00;
            end
            fetch_if.ifu_icu_cancel = ($urandom_range(0, 9) == 0);
            cycle();
            if (last_ack) fetch_if.ifu_icu_req_ic1 = 1'b0;
        end
        fetch_if.ifu_icu_req_ic1 = 1'b0;
        fetch_if.ifu_icu_cancel  = 1'b0;
        run(12);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
